// File: rtl/note_priority_sequencer_pkg.sv
// note_priority_sequencer_pkg: scan-code constants and parser state encoding
package note_priority_sequencer_pkg;
    localparam logic [7:0] SC_F0  = 8'hF0;
    localparam logic [7:0] SC_E0  = 8'hE0;
    localparam logic [7:0] SC_ESC = 8'h76;
    localparam logic [7:0] SC_AA  = 8'hAA;
    localparam logic [7:0] SC_FA  = 8'hFA;
    localparam logic [7:0] SC_FE  = 8'hFE;
    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BRK} state_t;
endpackage

// File: rtl/note_priority_sequencer_scan_to_note.sv
// scan_to_note: maps a PS/2 set-2 make code to a piano note id, 0 when unmapped
module scan_to_note #(
    parameter int NOTE_W = 5
) (
    input  logic [7:0]        code,
    output logic [NOTE_W-1:0] note
);
    logic [4:0] id;
    always_comb begin
        case (code)
            8'h15: id = 5'd1;
            8'h1E: id = 5'd2;
            8'h1D: id = 5'd3;
            8'h26: id = 5'd4;
            8'h24: id = 5'd5;
            8'h25: id = 5'd6;
            8'h2D: id = 5'd7;
            8'h2E: id = 5'd8;
            8'h2C: id = 5'd9;
            8'h36: id = 5'd10;
            8'h35: id = 5'd11;
            8'h3D: id = 5'd12;
            8'h3C: id = 5'd13;
            8'h3E: id = 5'd14;
            8'h43: id = 5'd15;
            8'h1C: id = 5'd16;
            8'h1B: id = 5'd17;
            8'h23: id = 5'd18;
            8'h2B: id = 5'd19;
            8'h34: id = 5'd20;
            8'h33: id = 5'd21;
            8'h44: id = 5'd22;
            default: id = 5'd0;
        endcase
        note = NOTE_W'(id);
    end
endmodule

// File: rtl/note_priority_sequencer.sv
// note_priority_sequencer: scan-code parser driving a most-recent-first held-note stack
module note_priority_sequencer
    import note_priority_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH    = 8,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int NOTE_W         = 5
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              code_valid,
    input  logic [7:0]        code,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_change,
    output logic [4:0]        stack_count,
    output logic              seq_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_t                  state_q;
    logic [TW-1:0]           tmo_q;
    logic [NOTE_W-1:0]       stack_q [STACK_DEPTH];
    logic [NOTE_W-1:0]       stack_d [STACK_DEPTH];
    logic [4:0]              count_q, count_d;
    logic [NOTE_W-1:0]       note_out_q;
    logic                    note_change_q, seq_error_q;
    logic [NOTE_W-1:0]       note;
    logic [STACK_DEPTH-1:0]  hit;
    logic                    press, rel, clr, found, below;

    scan_to_note #(.NOTE_W(NOTE_W)) u_map (.code(code), .note(note));

    // index 0 is the most recent key; slots at or beyond count_q hold 0
    always_comb begin
        stack_d = stack_q;
        count_d = count_q;
        below   = 1'b0;
        press   = code_valid && state_q == S_IDLE && note != '0;
        rel     = code_valid && state_q == S_BREAK && note != '0;
        clr     = code_valid && state_q == S_IDLE && code == SC_ESC;
        for (int i = 0; i < STACK_DEPTH; i++) hit[i] = note != '0 && stack_q[i] == note;
        found = |hit;
        if (clr) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_d[i] = '0;
            count_d = '0;
        end else if (press && !found) begin
            stack_d[0] = note;
            for (int i = 1; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i-1];
            count_d = count_q == 5'(STACK_DEPTH) ? count_q : count_q + 5'd1;
        end else if (rel && found) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                below = below | hit[i];
                stack_d[i] = below ? stack_q[i+1] : stack_q[i];
            end
            stack_d[STACK_DEPTH-1] = '0;
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            tmo_q         <= '0;
            stack_q       <= '{default: '0};
            count_q       <= '0;
            note_out_q    <= '0;
            note_change_q <= 1'b0;
            seq_error_q   <= 1'b0;
        end else begin
            stack_q       <= stack_d;
            count_q       <= count_d;
            note_out_q    <= stack_d[0];
            note_change_q <= stack_d[0] != note_out_q;
            seq_error_q   <= 1'b0;
            if (code_valid) begin
                tmo_q   <= '0;
                state_q <= state_q == S_IDLE ? (code == SC_F0 ? S_BREAK : code == SC_E0 ? S_EXT : S_IDLE)
                         : (state_q == S_EXT && code == SC_F0) ? S_EXT_BRK : S_IDLE;
            end else if (state_q != S_IDLE) begin
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q     <= S_IDLE;
                    tmo_q       <= '0;
                    seq_error_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    assign note_out    = note_out_q;
    assign note_change = note_change_q;
    assign stack_count = count_q;
    assign seq_error   = seq_error_q;
endmodule

// File: tb/tb_note_priority_sequencer.sv
// tb_note_priority_sequencer: table, directed and random checks against a queue-based model
module tb_note_priority_sequencer;
    localparam int DEPTH = 8;
    localparam int TMO   = 20;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic [4:0] note_out;
    logic       note_change;
    logic [4:0] stack_count;
    logic       seq_error;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] keys [22] = '{8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h25, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35,
                              8'h3D, 8'h3C, 8'h3E, 8'h43, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h44};

    int         mq [$];
    logic [7:0] pend [$];
    int         idle = 0;
    int         m_note = 0;
    int         m_chg = 0;
    int         m_err = 0;

    typedef struct {
        logic       v;
        logic [7:0] c;
        int         note;
        int         cnt;
        int         chg;
    } vec_t;
    vec_t tbl [$];

    always #5 CLOCK_50 = ~CLOCK_50;

    note_priority_sequencer #(.STACK_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .NOTE_W(5)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .code_valid(code_valid), .code(code),
        .note_out(note_out), .note_change(note_change), .stack_count(stack_count), .seq_error(seq_error)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int map_code(input logic [7:0] c);
        for (int i = 0; i < 22; i++) if (keys[i] == c) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        pend.delete();
        idle = 0;
        m_note = 0;
        m_chg = 0;
        m_err = 0;
    endtask

    task automatic model(input logic v, input logic [7:0] c);
        int n, prev, idx;
        bit present;
        prev = m_note;
        m_err = 0;
        if (v) begin
            idle = 0;
            n = map_code(c);
            if (pend.size() == 0) begin
                if (c == 8'hF0 || c == 8'hE0) pend.push_back(c);
                else if (c == 8'h76) mq.delete();
                else if (n != 0) begin
                    present = 0;
                    foreach (mq[i]) if (mq[i] == n) present = 1;
                    if (!present) begin
                        mq.push_front(n);
                        if (mq.size() > DEPTH) void'(mq.pop_back());
                    end
                end
            end else if (pend.size() == 1 && pend[0] == 8'hE0 && c == 8'hF0) begin
                pend.push_back(c);
            end else begin
                if (pend.size() == 1 && pend[0] == 8'hF0 && n != 0) begin
                    idx = -1;
                    foreach (mq[i]) if (mq[i] == n) idx = i;
                    if (idx >= 0) mq.delete(idx);
                end
                pend.delete();
            end
        end else if (pend.size() != 0) begin
            idle++;
            if (idle == TMO) begin
                pend.delete();
                idle = 0;
                m_err = 1;
            end
        end
        m_note = mq.size() != 0 ? mq[0] : 0;
        m_chg = m_note != prev;
    endtask

    task automatic step(input logic v, input logic [7:0] c);
        @(negedge CLOCK_50);
        code_valid = v;
        code = c;
        @(posedge CLOCK_50);
        #1;
        code_valid = 1'b0;
        model(v, c);
        chk("model note_out", int'(note_out), m_note);
        chk("model stack_count", int'(stack_count), mq.size());
        chk("model note_change", int'(note_change), m_chg);
        chk("model seq_error", int'(seq_error), m_err);
    endtask

    task automatic press_seq(input logic [7:0] c);
        step(1'b1, c);
    endtask

    task automatic release_seq(input logic [7:0] c);
        step(1'b1, 8'hF0);
        step(1'b1, c);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        #1;
        chk("reset note_out", int'(note_out), 0);
        chk("reset stack_count", int'(stack_count), 0);
        chk("reset note_change", int'(note_change), 0);
        chk("reset seq_error", int'(seq_error), 0);
        model_reset();
        @(negedge CLOCK_50);
        resetn = 1'b1;

        tbl.push_back('{1'b1, 8'h15, 1, 1, 1});
        tbl.push_back('{1'b0, 8'h00, 1, 1, 0});
        tbl.push_back('{1'b1, 8'hF0, 1, 1, 0});
        tbl.push_back('{1'b1, 8'h15, 0, 0, 1});
        tbl.push_back('{1'b1, 8'h15, 1, 1, 1});
        tbl.push_back('{1'b1, 8'h1D, 3, 2, 1});
        tbl.push_back('{1'b1, 8'h24, 5, 3, 1});
        tbl.push_back('{1'b1, 8'hF0, 5, 3, 0});
        tbl.push_back('{1'b1, 8'h1D, 5, 2, 0});
        tbl.push_back('{1'b1, 8'hF0, 5, 2, 0});
        tbl.push_back('{1'b1, 8'h24, 1, 1, 1});
        tbl.push_back('{1'b1, 8'hF0, 1, 1, 0});
        tbl.push_back('{1'b1, 8'h15, 0, 0, 1});
        tbl.push_back('{1'b1, 8'h15, 1, 1, 1});
        for (int k = 0; k < 4; k++) tbl.push_back('{1'b1, 8'h15, 1, 1, 0});
        tbl.push_back('{1'b0, 8'h00, 1, 1, 0});
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].v, tbl[k].c);
            chk("table note_out", int'(note_out), tbl[k].note);
            chk("table stack_count", int'(stack_count), tbl[k].cnt);
            chk("table note_change", int'(note_change), tbl[k].chg);
        end

        // overflow: nine distinct keys into an eight-deep stack
        press_seq(8'h76);
        for (int k = 0; k < 9; k++) press_seq(keys[k]);
        chk("full count", int'(stack_count), 8);
        chk("full top", int'(note_out), 9);
        release_seq(8'h15);
        chk("evicted release count", int'(stack_count), 8);
        chk("evicted release top", int'(note_out), 9);
        chk("evicted release change", int'(note_change), 0);
        release_seq(8'h1E);
        chk("oldest held release count", int'(stack_count), 7);

        // extended sequences are ignored, then a prefix timeout
        press_seq(8'h76);
        chk("esc clears", int'(stack_count), 0);
        press_seq(8'h1D);
        step(1'b1, 8'hE0); step(1'b1, 8'h75);
        step(1'b1, 8'hE0); step(1'b1, 8'hF0); step(1'b1, 8'h75);
        chk("ext note_out", int'(note_out), 3);
        chk("ext count", int'(stack_count), 1);
        step(1'b1, 8'hF0);
        for (int k = 0; k < TMO - 1; k++) begin
            step(1'b0, 8'h00);
            chk("timeout early", int'(seq_error), 0);
        end
        step(1'b0, 8'h00);
        chk("timeout pulse", int'(seq_error), 1);
        chk("timeout no stack change", int'(stack_count), 1);
        step(1'b0, 8'h00);
        chk("timeout pulse width", int'(seq_error), 0);
        press_seq(8'h15);
        chk("press after timeout", int'(note_out), 1);
        chk("count after timeout", int'(stack_count), 2);

        // reset in the middle of a break sequence
        press_seq(8'h76);
        press_seq(8'h15);
        press_seq(8'h1D);
        step(1'b1, 8'hF0);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        #1;
        chk("midreset note_out", int'(note_out), 0);
        chk("midreset count", int'(stack_count), 0);
        chk("midreset change", int'(note_change), 0);
        chk("midreset error", int'(seq_error), 0);
        model_reset();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        press_seq(8'h1D);
        chk("post reset press", int'(note_out), 3);
        chk("post reset count", int'(stack_count), 1);
        press_seq(8'h76);
        chk("esc note_out", int'(note_out), 0);
        chk("esc count", int'(stack_count), 0);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                for (int j = 0; j < TMO + 5; j++) step(1'b0, 8'h00);
            end else begin
                r = $urandom_range(0, 19);
                b = r < 11 ? keys[$urandom_range(0, 21)]
                  : r < 15 ? 8'hF0
                  : r < 17 ? 8'hE0
                  : r < 18 ? 8'h76
                  : 8'($urandom_range(0, 255));
                step(1'($urandom_range(0, 1)), b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
